// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_cmd_sequencer: IDLE/EXEC/DONE sequencer feeding an external comb ALU.  |
// | Macro ALU_SEQ_CHAIN_EN: in_chain swaps operand A for the previous result.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_cmd_sequencer #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic [2:0]   in_op,
   input  logic         in_chain,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [2:0]   alu_sel,
   input  logic [N-1:0] alu_y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic [7:0]   op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic         ready_q, ready_d;
   logic         out_valid_q, out_valid_d;
   logic [N-1:0] alu_a_q, alu_a_d;
   logic [N-1:0] alu_b_q, alu_b_d;
   logic [2:0]   alu_sel_q, alu_sel_d;
   logic [N-1:0] out_result_q, out_result_d;
   logic [7:0]   op_count_q, op_count_d;
   logic [N-1:0] a_src;

`ifdef ALU_SEQ_CHAIN_EN
   logic [N-1:0] last_result_q, last_result_d;

   assign a_src = in_chain ? last_result_q : in_a;

   always_comb begin
      last_result_d = last_result_q;
      if (state_q == EXEC) begin
         last_result_d = alu_y;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_result_q <= '0;
      end else begin
         last_result_q <= last_result_d;
      end
   end
`else
   logic unused_chain;

   assign unused_chain = in_chain;
   assign a_src        = in_a;
`endif

   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_sel_d    = alu_sel_q;
      out_result_d = out_result_q;
      op_count_d   = op_count_q;
      case (state_q)
         IDLE: begin
            if (in_valid && ready_q) begin
               alu_a_d   = a_src;
               alu_b_d   = in_b;
               alu_sel_d = in_op;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            out_result_d = alu_y;
            out_valid_d  = 1'b1;
            state_d      = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               op_count_d  = op_count_q + 8'd1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
      // Ready is registered so it reads 0 throughout reset and 1 from the first edge after release.
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ready_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sel_q    <= '0;
         out_result_q <= '0;
         op_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         ready_q      <= ready_d;
         out_valid_q  <= out_valid_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_sel_q    <= alu_sel_d;
         out_result_q <= out_result_d;
         op_count_q   <= op_count_d;
      end
   end

   assign in_ready   = ready_q;
   assign out_valid  = out_valid_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_sel    = alu_sel_q;
   assign out_result = out_result_q;
   assign op_count   = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_cmd_sequencer: randomized bench with a behavioural ALU/sequencer    |
// | model. Rev 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_alu_cmd_sequencer;
   localparam int N = 8;
`ifdef ALU_SEQ_CHAIN_EN
   localparam bit CHAIN = 1'b1;
`else
   localparam bit CHAIN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, in_chain, out_valid, out_ready;
   logic [N-1:0] in_a, in_b, alu_a, alu_b, alu_y, out_result;
   logic [2:0]   in_op, alu_sel;
   logic [7:0]   op_count;

   int           tests = 0;
   int           fails = 0;
   logic [7:0]   m_last;
   int           m_count;

   always #5 clk = ~clk;

   function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return ~(a & b);
         3'd3:    return ~(a | b);
         3'd4:    return a ^ b;
         3'd5:    return ~(a ^ b);
         3'd6:    return a << 1;
         default: return a >> 1;
      endcase
   endfunction

   assign alu_y = ref_alu(alu_a, alu_b, alu_sel);

   alu_cmd_sequencer #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .op_count(op_count)
   );

   // Issues one command, waits for the result, holds it `hold` cycles, then hands it off.
   task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          input logic ch, input int hold,
                          output logic [7:0] res, output logic [7:0] exp,
                          output int lat, output bit ok);
      int n;
      ok  = 1'b1;
      exp = ref_alu((CHAIN && ch) ? m_last : a, b, op);
      @(negedge clk);
      in_a = a; in_b = b; in_op = op; in_chain = ch; in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) ok = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      n   = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         n++;
      end
      if (out_valid !== 1'b1) ok = 1'b0;
      res = out_result;
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      m_last  = exp;
      m_count = (m_count + 1) % 256;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      m_count = 0;
      m_last  = 8'h00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_op = '0; in_chain = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      tests++;
      if (op_count !== 8'h00) begin fails++; $display("FAIL reset_op_count got %h want 00", op_count); end
      tests++;
      if ({alu_a, alu_b, alu_sel} !== 19'h0) begin
         fails++; $display("FAIL reset_alu_regs got %h %h %h want 0", alu_a, alu_b, alu_sel);
      end
      tests++;
      if (out_result !== 8'h00) begin fails++; $display("FAIL reset_out_result got %h want 00", out_result); end
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
      m_count = 0;
      m_last  = 8'h00;
   endtask

   task automatic test_basic();
      logic [7:0] res, exp;
      int lat;
      bit ok;
      run_cmd(8'hF0, 8'h3C, 3'd0, 1'b0, 1, res, exp, lat, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL basic_timeout got no handshake want one"); end
      tests++;
      if (res !== 8'h30) begin fails++; $display("FAIL basic_and got %h want 30", res); end
      tests++;
      if (lat != 2) begin fails++; $display("FAIL basic_latency got %0d edges want 2", lat); end
      @(negedge clk);
      tests++;
      if (op_count !== 8'd1) begin fails++; $display("FAIL basic_op_count got %0d want 1", op_count); end
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop got %b want 0", out_valid); end
   endtask

   task automatic test_shift();
      logic [7:0] res, exp;
      int lat;
      bit ok;
      run_cmd(8'h81, 8'h00, 3'd6, 1'b0, 0, res, exp, lat, ok);
      tests++;
      if (!ok || res !== 8'h02) begin fails++; $display("FAIL shift_left got %h want 02", res); end
      run_cmd(8'h81, 8'h00, 3'd7, 1'b0, 0, res, exp, lat, ok);
      tests++;
      if (!ok || res !== 8'h40) begin fails++; $display("FAIL shift_right got %h want 40", res); end
   endtask

   task automatic test_chain();
      logic [7:0] res, exp, want;
      int lat;
      bit ok;
      run_cmd(8'h0F, 8'hF0, 3'd1, 1'b0, 0, res, exp, lat, ok);
      tests++;
      if (!ok || res !== 8'hFF) begin fails++; $display("FAIL chain_seed got %h want FF", res); end
      want = CHAIN ? 8'hF0 : 8'h0F;
      run_cmd(8'h00, 8'h0F, 3'd4, 1'b1, 0, res, exp, lat, ok);
      tests++;
      if (!ok || res !== want) begin fails++; $display("FAIL chain_xor got %h want %h", res, want); end
   endtask

   task automatic test_random();
      logic [7:0] res, exp;
      int lat;
      bit ok;
      for (int i = 0; i < 40; i++) begin
         run_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)), res, exp, lat, ok);
         tests++;
         if (!ok || res !== exp || lat != 2) begin
            fails++; $display("FAIL random_%0d got %h lat %0d want %h lat 2", i, res, lat, exp);
         end
         @(negedge clk);
         tests++;
         if (op_count !== m_count[7:0]) begin
            fails++; $display("FAIL random_count_%0d got %0d want %0d", i, op_count, m_count);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp, a_eff;
      logic [7:0] a, b;
      int n;
      a = 8'h5A; b = 8'hC3;
      a_eff = a;
      exp = ref_alu(a_eff, b, 3'd5);
      @(negedge clk);
      in_a = a; in_b = b; in_op = 3'd5; in_chain = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_a = ~a; in_b = ~b; in_op = 3'd0;
      n = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      tests++;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_timeout got no out_valid want 1"); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (out_result !== exp || in_ready !== 1'b0 || out_valid !== 1'b1 || alu_a !== a_eff
             || alu_b !== b || alu_sel !== 3'd5) begin
            fails++;
            $display("FAIL bp_hold_%0d got res %h rdy %b vld %b a %h b %h sel %0d want %h 0 1 %h %h 5",
                     i, out_result, in_ready, out_valid, alu_a, alu_b, alu_sel, exp, a_eff, b);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      m_last  = exp;
      m_count = (m_count + 1) % 256;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || op_count !== m_count[7:0] || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_release got vld %b cnt %0d rdy %b want 0 %0d 1", out_valid, op_count,
                  in_ready, m_count);
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || op_count !== m_count[7:0]) begin
         fails++; $display("FAIL bp_single got vld %b cnt %0d want 0 %0d", out_valid, op_count, m_count);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] res, exp;
      int lat, n;
      bit ok;
      @(negedge clk);
      in_a = 8'hA5; in_b = 8'h0F; in_op = 3'd1; in_chain = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      tests++;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL rmid_reach_done got %b want 1", out_valid); end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || op_count !== 8'h00 || in_ready !== 1'b0 || out_result !== 8'h00) begin
         fails++;
         $display("FAIL rmid_in_reset got vld %b cnt %0d rdy %b res %h want 0 0 0 00",
                  out_valid, op_count, in_ready, out_result);
      end
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || op_count !== 8'h00) begin
         fails++; $display("FAIL rmid_release got rdy %b cnt %0d want 1 0", in_ready, op_count);
      end
      m_count = 0;
      m_last  = 8'h00;
      run_cmd(8'h33, 8'h55, 3'd4, 1'b1, 0, res, exp, lat, ok);
      tests++;
      if (!ok || res !== (CHAIN ? 8'h55 : 8'h66)) begin
         fails++; $display("FAIL rmid_last_cleared got %h want %h", res, CHAIN ? 8'h55 : 8'h66);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] res, exp;
      int lat, bad;
      bit ok;
      apply_reset();
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         run_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 0, res, exp, lat, ok);
         if (!ok || res !== exp) bad++;
         if (i == 254) begin
            @(negedge clk);
            tests++;
            if (op_count !== 8'd255) begin fails++; $display("FAIL wrap_255 got %0d want 255", op_count); end
         end
      end
      @(negedge clk);
      tests++;
      if (op_count !== 8'h00) begin fails++; $display("FAIL wrap_zero got %h want 00", op_count); end
      tests++;
      if (bad != 0) begin fails++; $display("FAIL wrap_results got %0d bad want 0", bad); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_count = 0;
      m_last  = 8'h00;
      test_reset();
      test_basic();
      test_shift();
      test_chain();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
